// File: rtl/pulse_stretch_pkg.sv
// pulse_stretch_pkg: shared state encoding and polarity names for the pulse stretcher
package pulse_stretch_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON = 2'd1;
  localparam logic [1:0] ST_OFF = 2'd2;
  localparam string POL_HIGH = "HIGH";
  localparam string POL_LOW = "LOW";
endpackage

// File: rtl/pulse_stretch_ch.sv
// pulse_stretch_ch: one stretcher channel (edge detect, ON/OFF timing, single pending event)
// Ports: clk, reset_n (async active-low), data_in (active-high event input),
//        data_out (registered active-high pulse), busy (not idle or event pending)
module pulse_stretch_ch
  import pulse_stretch_pkg::*;
#(
  parameter int ON_TIME = 50000,
  parameter int OFF_TIME = 50000,
  parameter int TIME_WIDTH = 16,
  parameter int RETRIGGER = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic data_in,
  output logic data_out,
  output logic busy
);
  localparam logic [TIME_WIDTH-1:0] ON_LAST = TIME_WIDTH'(ON_TIME - 1);
  localparam logic [TIME_WIDTH-1:0] OFF_LAST = TIME_WIDTH'(OFF_TIME == 0 ? 0 : OFF_TIME - 1);
  logic [1:0] state, state_nx;
  logic [TIME_WIDTH-1:0] cnt, cnt_nx;
  logic pend, pend_nx, prev, armed, ev;
  // armed stays low after reset until the input is seen inactive, so a level
  // held through reset release never counts as an event
  assign ev = data_in & ~prev & armed;
  assign busy = (state != ST_IDLE) | pend;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    pend_nx = pend;
    if (state == ST_ON) begin
      if (cnt == ON_LAST && !data_in) begin
        state_nx = OFF_TIME == 0 ? ST_IDLE : ST_OFF;
        cnt_nx = '0;
      end else begin
        cnt_nx = (RETRIGGER != 0 && ev) ? '0 : (cnt == ON_LAST ? cnt : cnt + 1'b1);
        pend_nx = pend | (RETRIGGER == 0 && ev);
      end
    end else if (state == ST_OFF) begin
      if (cnt == OFF_LAST) begin
        state_nx = (pend | ev) ? ST_ON : ST_IDLE;
        cnt_nx = '0;
        pend_nx = 1'b0;
      end else begin
        cnt_nx = cnt + 1'b1;
        pend_nx = pend | ev;
      end
    end else if (ev | pend) begin
      // pending can survive into IDLE only when there is no OFF gap
      state_nx = ST_ON;
      cnt_nx = '0;
      pend_nx = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      pend <= 1'b0;
      prev <= 1'b0;
      armed <= 1'b0;
      data_out <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      pend <= pend_nx;
      prev <= data_in;
      armed <= armed | ~data_in;
      data_out <= state_nx == ST_ON;
    end
  end
endmodule

// File: rtl/pulse_stretch.sv
// pulse_stretch: per-bit minimum-width pulse stretcher with minimum inactive gap
// Ports: clk, reset_n (async active-low), data_in[DATA_WIDTH] (events),
//        data_out[DATA_WIDTH] (stretched pulses), busy[DATA_WIDTH] (channel active or pending)
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter string POLARITY = "HIGH",
  parameter int ON_TIME = 50000,
  parameter int OFF_TIME = 50000,
  parameter int TIME_WIDTH = 16,
  parameter int RETRIGGER = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] busy
);
  localparam bit ACT_LOW = POLARITY == POL_LOW;
  logic [DATA_WIDTH-1:0] act_in, act_out;
  assign act_in = ACT_LOW ? ~data_in : data_in;
  // the inversion follows a flop, so the pin stays glitch-free and resets inactive
  assign data_out = ACT_LOW ? ~act_out : act_out;
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_ch
    pulse_stretch_ch #(
      .ON_TIME(ON_TIME),
      .OFF_TIME(OFF_TIME),
      .TIME_WIDTH(TIME_WIDTH),
      .RETRIGGER(RETRIGGER)
    ) u_ch (
      .clk(clk),
      .reset_n(reset_n),
      .data_in(act_in[i]),
      .data_out(act_out[i]),
      .busy(busy[i])
    );
  end
endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: directed and random checks of four pulse_stretch configurations against a timing model
module tb_pulse_stretch;
  localparam int ON_T = 5;
  localparam int OFF_T[4] = '{3, 3, 3, 0};
  localparam bit RT[4] = '{0, 1, 0, 0};
  localparam bit LP[4] = '{0, 0, 1, 0};
  logic clk = 0;
  logic reset_n = 0;
  logic [3:0][3:0] din, dout, bsy;
  int ncmp = 0, nerr = 0;
  int on_age[4][4], gap_age[4][4];
  bit pend_m[4][4], prev_m[4][4];
  always #5 clk = ~clk;
  pulse_stretch #(.DATA_WIDTH(4), .POLARITY("HIGH"), .ON_TIME(5), .OFF_TIME(3), .TIME_WIDTH(4), .RETRIGGER(0))
    dut_a (.clk(clk), .reset_n(reset_n), .data_in(din[0]), .data_out(dout[0]), .busy(bsy[0]));
  pulse_stretch #(.DATA_WIDTH(4), .POLARITY("HIGH"), .ON_TIME(5), .OFF_TIME(3), .TIME_WIDTH(4), .RETRIGGER(1))
    dut_r (.clk(clk), .reset_n(reset_n), .data_in(din[1]), .data_out(dout[1]), .busy(bsy[1]));
  pulse_stretch #(.DATA_WIDTH(4), .POLARITY("LOW"), .ON_TIME(5), .OFF_TIME(3), .TIME_WIDTH(4), .RETRIGGER(0))
    dut_l (.clk(clk), .reset_n(reset_n), .data_in(din[2]), .data_out(dout[2]), .busy(bsy[2]));
  pulse_stretch #(.DATA_WIDTH(4), .POLARITY("HIGH"), .ON_TIME(5), .OFF_TIME(0), .TIME_WIDTH(4), .RETRIGGER(0))
    dut_z (.clk(clk), .reset_n(reset_n), .data_in(din[3]), .data_out(dout[3]), .busy(bsy[3]));

  // Model: a channel is "on" for on_age cycles so far, or "in gap" for gap_age cycles so far
  task automatic model_reset();
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 4; c++) begin
        on_age[d][c] = -1;
        gap_age[d][c] = -1;
        pend_m[d][c] = 0;
        prev_m[d][c] = 1;
      end
  endtask

  task automatic model_edge();
    bit a, ev;
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 4; c++) begin
        a = din[d][c] ^ LP[d];
        ev = a && !prev_m[d][c];
        prev_m[d][c] = a;
        if (on_age[d][c] >= 0) begin
          if (on_age[d][c] >= ON_T - 1 && !a) begin
            on_age[d][c] = -1;
            if (OFF_T[d] > 0) gap_age[d][c] = 0;
          end else begin
            on_age[d][c] = (RT[d] && ev) ? 0 : on_age[d][c] + 1;
            if (!RT[d] && ev) pend_m[d][c] = 1;
          end
        end else if (gap_age[d][c] >= 0) begin
          if (gap_age[d][c] == OFF_T[d] - 1) begin
            gap_age[d][c] = -1;
            if (pend_m[d][c] || ev) on_age[d][c] = 0;
            pend_m[d][c] = 0;
          end else begin
            gap_age[d][c]++;
            if (ev) pend_m[d][c] = 1;
          end
        end else if (ev || pend_m[d][c]) begin
          on_age[d][c] = 0;
          pend_m[d][c] = 0;
        end
      end
  endtask

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [3:0] eo, eb;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        eo[c] = (on_age[d][c] >= 0) ^ LP[d];
        eb[c] = on_age[d][c] >= 0 || gap_age[d][c] >= 0 || pend_m[d][c];
      end
      chk($sformatf("data_out[dut%0d]", d), dout[d], eo);
      chk($sformatf("busy[dut%0d]", d), bsy[d], eb);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      if (reset_n) model_edge();
      #1;
      check_all();
    end
  endtask

  task automatic set_in(int d, int c, bit v);
    din[d][c] = v ^ LP[d];
  endtask

  task automatic pulse_all(int c, int len);
    for (int d = 0; d < 4; d++) set_in(d, c, 1);
    cyc(len);
    for (int d = 0; d < 4; d++) set_in(d, c, 0);
  endtask

  // Asserted mid-cycle so the asynchronous clear is checked before any clock edge
  task automatic mid_reset(int hold);
    #1;
    reset_n = 0;
    model_reset();
    #1;
    check_all();
    cyc(hold);
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    din = {$urandom(), $urandom()};
    model_reset();
    #3;
    check_all();
    cyc(2);
    din = '0;
    for (int d = 0; d < 4; d++) set_in(d, 0, 1);
    for (int d = 0; d < 4; d++) set_in(d, 3, 0);
    din[2][3:1] = 3'b111;
    @(negedge clk);
    reset_n = 1;
    cyc(8);
    for (int d = 0; d < 4; d++) set_in(d, 0, 0);
    cyc(2);
    pulse_all(0, 1);
    cyc(12);
    pulse_all(1, 10);
    cyc(12);
    repeat (3) begin
      pulse_all(2, 1);
      cyc(1);
    end
    cyc(15);
    pulse_all(2, 1);
    cyc(8);
    pulse_all(2, 1);
    cyc(14);
    pulse_all(3, 1);
    cyc(7);
    pulse_all(3, 1);
    cyc(14);
    pulse_all(3, 1);
    cyc(2);
    pulse_all(3, 1);
    cyc(12);
    pulse_all(0, 1);
    cyc(2);
    pulse_all(0, 1);
    mid_reset(2);
    cyc(12);
    for (int k = 0; k < 800; k++) begin
      for (int d = 0; d < 4; d++)
        for (int c = 0; c < 4; c++)
          if ($urandom_range(3) == 0) din[d][c] = ~din[d][c];
      if ($urandom_range(149) == 0) mid_reset($urandom_range(3));
      else cyc(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
